// File: rtl/des_key_sched.sv
// DES key schedule: forms C0/D0 from the 64-bit key (PC-1 or direct),
// then emits the 16 PC-2 round keys, one per accepted handshake, in
// encrypt (K1..K16) or decrypt (K16..K1) order with ready/valid flow control.
module des_key_sched #(
    parameter logic [15:0] SHIFT_SCHEDULE = 16'h8103,
    parameter bit          PC1_EN         = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [63:0] i_key,
    input  logic        i_encrypt,
    input  logic        i_abort,
    input  logic        i_key_rdy,
    output logic        o_ready,
    output logic [47:0] o_key,
    output logic        o_key_vld,
    output logic [3:0]  o_round,
    output logic        o_last,
    output logic        o_encrypt
);

    typedef enum logic {IDLE, RUN} state_t;

    // DES bit numbers (1 = MSB) of the key feeding each C0/D0 bit, MSB first.
    localparam logic [447:0] PC1_TAB = {
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd63, 8'd55, 8'd47, 8'd39,
        8'd31, 8'd23, 8'd15, 8'd7,  8'd62, 8'd54, 8'd46, 8'd38,
        8'd30, 8'd22, 8'd14, 8'd6,  8'd61, 8'd53, 8'd45, 8'd37,
        8'd29, 8'd21, 8'd13, 8'd5,  8'd28, 8'd20, 8'd12, 8'd4
    };

    // Bit numbers (1 = MSB of C) of the 56-bit C||D feeding each round-key bit.
    localparam logic [383:0] PC2_TAB = {
        8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
        8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
        8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
        8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
        8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
        8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32
    };

    function automatic logic [55:0] pc1_f(input logic [63:0] key);
        logic [447:0] tab;
        logic [55:0]  res;
        logic [5:0]   idx;
        tab = PC1_TAB;
        res = '0;
        for (int i = 0; i < 56; i++) begin
            idx = 6'(8'd64 - tab[447:440]);
            res = {res[54:0], key[idx]};
            tab = {tab[439:0], 8'd0};
        end
        return res;
    endfunction

    function automatic logic [47:0] pc2_f(input logic [55:0] cd);
        logic [383:0] tab;
        logic [47:0]  res;
        logic [5:0]   idx;
        tab = PC2_TAB;
        res = '0;
        for (int i = 0; i < 48; i++) begin
            idx = 6'(8'd56 - tab[383:376]);
            res = {res[46:0], cd[idx]};
            tab = {tab[375:0], 8'd0};
        end
        return res;
    endfunction

    function automatic logic [27:0] rot_l(input logic [27:0] v, input logic by1);
        return by1 ? {v[26:0], v[27]} : {v[25:0], v[27:26]};
    endfunction

    function automatic logic [27:0] rot_r(input logic [27:0] v, input logic by1);
        return by1 ? {v[0], v[27:1]} : {v[1:0], v[27:2]};
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d, d_q, d_d;
    logic [47:0] key_q, key_d;
    logic [3:0]  round_q, round_d;
    logic        enc_q, enc_d;
    logic [55:0] cd0;
    logic [3:0]  sidx;
    logic        shift_one;

    // Parity bits (and, without PC-1, the top byte) never reach a round key.
    logic unused_key_bits;
    assign unused_key_bits = ^i_key;

    // Next-state: load on accept, rotate and re-permute on each handshake.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        key_d     = key_q;
        round_d   = round_q;
        enc_d     = enc_q;
        sidx      = '0;
        shift_one = 1'b0;
        cd0       = PC1_EN ? pc1_f(i_key) : i_key[55:0];

        case (state_q)
            IDLE: begin
                if (i_start && !i_abort) begin
                    state_d = RUN;
                    enc_d   = i_encrypt;
                    round_d = 4'd0;
                    if (i_encrypt) begin
                        c_d = rot_l(cd0[55:28], SHIFT_SCHEDULE[0]);
                        d_d = rot_l(cd0[27:0], SHIFT_SCHEDULE[0]);
                    end else begin
                        c_d = cd0[55:28];
                        d_d = cd0[27:0];
                    end
                    key_d = pc2_f({c_d, d_d});
                end
            end
            RUN: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (i_key_rdy) begin
                    if (round_q == 4'd15) begin
                        state_d = IDLE;
                    end else begin
                        round_d = round_q + 4'd1;
                        if (enc_q) begin
                            sidx      = round_q + 4'd1;
                            shift_one = SHIFT_SCHEDULE[sidx];
                            c_d       = rot_l(c_q, shift_one);
                            d_d       = rot_l(d_q, shift_one);
                        end else begin
                            sidx      = 4'd15 - round_q;
                            shift_one = SHIFT_SCHEDULE[sidx];
                            c_d       = rot_r(c_q, shift_one);
                            d_d       = rot_r(d_q, shift_one);
                        end
                        key_d = pc2_f({c_d, d_d});
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            key_q   <= '0;
            round_q <= '0;
            enc_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            key_q   <= key_d;
            round_q <= round_d;
            enc_q   <= enc_d;
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_key_vld = (state_q == RUN);
    assign o_key     = key_q;
    assign o_round   = round_q;
    assign o_last    = o_key_vld && (round_q == 4'd15);
    assign o_encrypt = enc_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Bench for des_key_sched: table of key sequences run through a scoreboard,
// plus hand-written abort, start-in-run and mid-run reset sequences.
`timescale 1ns/1ps
module tb_des_key_sched;

    localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
    // C0 = F0CCAAF, D0 = 556678F; top byte is junk that must be ignored.
    localparam logic [63:0] KEY_NP = {8'hFF, 28'hF0CCAAF, 28'h556678F};

    logic [47:0] ktab [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [63:0] key_a = '0, key_b = '0;
    logic        enc = 1'b0, abort = 1'b0, rdy = 1'b0;
    logic        sel_b = 1'b0;

    logic        a_ready, a_vld, a_last, a_enc;
    logic [47:0] a_key;
    logic [3:0]  a_round;
    logic        b_ready, b_vld, b_last, b_enc;
    logic [47:0] b_key;
    logic [3:0]  b_round;

    logic        cur_ready, cur_vld, cur_last, cur_enc;
    logic [47:0] cur_key;
    logic [3:0]  cur_round;

    always #5 clk = ~clk;

    des_key_sched dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_key(key_a),
        .i_encrypt(enc), .i_abort(abort), .i_key_rdy(rdy),
        .o_ready(a_ready), .o_key(a_key), .o_key_vld(a_vld),
        .o_round(a_round), .o_last(a_last), .o_encrypt(a_enc)
    );

    des_key_sched #(.PC1_EN(1'b0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_key(key_b),
        .i_encrypt(enc), .i_abort(abort), .i_key_rdy(rdy),
        .o_ready(b_ready), .o_key(b_key), .o_key_vld(b_vld),
        .o_round(b_round), .o_last(b_last), .o_encrypt(b_enc)
    );

    assign cur_ready = sel_b ? b_ready : a_ready;
    assign cur_vld   = sel_b ? b_vld   : a_vld;
    assign cur_last  = sel_b ? b_last  : a_last;
    assign cur_enc   = sel_b ? b_enc   : a_enc;
    assign cur_key   = sel_b ? b_key   : a_key;
    assign cur_round = sel_b ? b_round : a_round;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [47:0] key;
        logic [3:0]  rnd;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string       name;
        logic        use_b;
        logic [63:0] key;
        logic        enc;
        int          stall_at;
        int          stall_len;
        logic        rand_rdy;
        int          poke_at;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full sequence, comparing every valid cycle against the queue head.
    task automatic run_vec(input vec_t v);
        exp_t e;
        int   stalled = 0;
        int   budget  = 0;
        bit   poked   = 0;
        sel_b = v.use_b;
        for (int i = 0; i < 16; i++) begin
            e.key = v.enc ? ktab[i] : ktab[15-i];
            e.rnd = 4'(i);
            sbq.push_back(e);
        end
        if (v.use_b) begin key_b = v.key; start_b = 1'b1; end
        else begin key_a = v.key; start_a = 1'b1; end
        enc = v.enc;
        rdy = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
        check({v.name, "_first_vld"}, cur_vld, 1);
        while (sbq.size() > 0 && budget < 200) begin
            budget++;
            if (!cur_vld) begin
                check({v.name, "_vld_dropped"}, cur_vld, 1);
                sbq.delete();
                break;
            end
            if (v.rand_rdy) rdy = ($urandom_range(0, 2) != 0);
            else if (cur_round == 4'(v.stall_at) && stalled < v.stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else rdy = 1'b1;
            check({v.name, "_key"}, cur_key, sbq[0].key);
            check({v.name, "_round"}, cur_round, sbq[0].rnd);
            check({v.name, "_last"}, cur_last, sbq[0].rnd == 4'd15);
            check({v.name, "_enc"}, cur_enc, v.enc);
            if (!poked && cur_round == 4'(v.poke_at)) begin
                poked = 1;
                if (v.use_b) begin key_b = ~v.key; start_b = 1'b1; end
                else begin key_a = ~v.key; start_a = 1'b1; end
                enc = ~v.enc;
            end
            if (rdy) void'(sbq.pop_front());
            step();
            start_a = 1'b0;
            start_b = 1'b0;
            enc = v.enc;
        end
        if (sbq.size() != 0) begin
            check({v.name, "_timeout"}, 64'(sbq.size()), 0);
            sbq.delete();
        end
        check({v.name, "_end_vld"}, cur_vld, 0);
        check({v.name, "_end_ready"}, cur_ready, 1);
        rdy = 1'b0;
    endtask

    task automatic wait_round(input logic [3:0] r, input string name);
        int budget = 0;
        while (!(a_vld && a_round == r) && budget < 40) begin
            step();
            budget++;
        end
        check(name, a_round, r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"enc",        1'b0, KEY,    1'b1, -1, 0, 1'b0, -1};
        vecs[1] = '{"dec",        1'b0, KEY,    1'b0, -1, 0, 1'b0, -1};
        vecs[2] = '{"enc_stall7", 1'b0, KEY,    1'b1,  7, 5, 1'b0, -1};
        vecs[3] = '{"dec_rand",   1'b0, KEY,    1'b0, -1, 0, 1'b1, -1};
        vecs[4] = '{"enc_nopc1",  1'b1, KEY_NP, 1'b1, -1, 0, 1'b1, -1};
        vecs[5] = '{"enc_poke",   1'b0, KEY,    1'b1, -1, 0, 1'b0,  2};

        // Reset values while reset is held.
        #12;
        check("rst_ready", a_ready, 1);
        check("rst_vld", a_vld, 0);
        check("rst_last", a_last, 0);
        check("rst_key", a_key, 0);
        check("rst_round", a_round, 0);
        check("rst_enc", a_enc, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
            if (i == 0) begin
                check("enc_final_c", dut_a.c_q, 28'hF0CCAAF);
                check("enc_final_d", dut_a.d_q, 28'h556678F);
                check("idle_key_held", a_key, ktab[15]);
            end
        end
        sel_b = 1'b0;

        // Abort at round 3 coincident with a handshake.
        key_a = KEY; enc = 1'b1; rdy = 1'b1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_round(4'd3, "abort_reach_r3");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_vld", a_vld, 0);
        check("abort_ready", a_ready, 1);
        // Abort together with start in IDLE: no accept.
        abort = 1'b1; start_a = 1'b1;
        step();
        abort = 1'b0; start_a = 1'b0;
        check("abort_start_vld", a_vld, 0);
        check("abort_start_ready", a_ready, 1);
        run_vec(vecs[0]);

        // Reset pulsed at round 9, checked before any further clock edge.
        key_a = KEY; enc = 1'b1; rdy = 1'b1; start_a = 1'b1;
        step();
        start_a = 1'b0;
        wait_round(4'd9, "rst_reach_r9");
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", a_ready, 1);
        check("midrst_vld", a_vld, 0);
        check("midrst_last", a_last, 0);
        check("midrst_key", a_key, 0);
        check("midrst_round", a_round, 0);
        check("midrst_enc", a_enc, 0);
        check("midrst_c", dut_a.c_q, 0);
        rst_n = 1'b1;
        run_vec(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
